redun_to_bin: RTL

REDUN_TO_BIN -- requirements
Module: redun_to_bin

---
 rtl/redun_to_bin.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/redun_to_bin.sv
// redun_to_bin
// Converts one operand held in redundant form into plain binary and streams it
// out one WRD_BITS-wide word per beat, least-significant word first.
//
// Each stored word is RED_BITS wide, but word i carries weight 2^(WRD_BITS*i).
// The bits above WRD_BITS therefore overlap the next word. The block resolves
// them with a running carry as it walks the words from the bottom up.
//
// Ports
//   i_clk   in   1                    clock, rising edge
//   i_rst   in   1                    asynchronous active-high reset
//   i_red   in   NUM_WRDS*RED_BITS    redundant operand, word i at [i*RED_BITS +: RED_BITS]
//   i_val   in   1                    i_red valid
//   o_rdy   out  1                    block can accept an operand
//   o_dat   out  WRD_BITS             binary output word
//   o_val   out  1                    o_dat valid
//   i_rdy   in   1                    downstream accepts o_dat
//   o_sop   out  1                    current beat is word 0
//   o_eop   out  1                    current beat is word NUM_WRDS-1
//   o_ovf   out  1                    final carry nonzero (eop beat only)
//
// Every output comes straight from a flop. The next beat is pre-computed one
// cycle ahead, so i_val and i_rdy have no combinational path to any output.

module redun_to_bin #(
   parameter int NUM_WRDS = 65,
   parameter int WRD_BITS = 16,
   parameter int RED_BITS = 17
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic [NUM_WRDS*RED_BITS-1:0] i_red,
   input  logic                         i_val,
   output logic                         o_rdy,
   output logic [WRD_BITS-1:0]          o_dat,
   output logic                         o_val,
   input  logic                         i_rdy,
   output logic                         o_sop,
   output logic                         o_eop,
   output logic                         o_ovf
);

   // The carry is one bit wider than the overlap between adjacent words. This
   // lets word + carry shifted down by WRD_BITS always fit, so it never wraps.
   localparam int CAR_BITS = RED_BITS - WRD_BITS + 1;
   localparam int SUM_BITS = RED_BITS + 1;
   localparam int IDX_BITS = (NUM_WRDS > 1) ? $clog2(NUM_WRDS) : 1;

   localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_WRDS - 1);
   localparam logic [IDX_BITS-1:0] IDX_ONE  = IDX_BITS'(1);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_t;

   state_t                        state_q, state_d;
   logic [IDX_BITS-1:0]           idx_q, idx_d;
   logic [CAR_BITS-1:0]           carry_q, carry_d;
   logic [CAR_BITS-1:0]           cnext_q, cnext_d;
   logic [NUM_WRDS*RED_BITS-1:0]  op_q, op_d;
   logic                          o_rdy_q, o_rdy_d;
   logic                          o_val_q, o_val_d;
   logic [WRD_BITS-1:0]           o_dat_q, o_dat_d;
   logic                          o_sop_q, o_sop_d;
   logic                          o_eop_q, o_eop_d;
   logic                          o_ovf_q, o_ovf_d;

   logic                          hs;
   logic                          load_beat;
   logic [RED_BITS-1:0]           nxt_word;
   logic [SUM_BITS-1:0]           nxt_sum;

   assign hs = o_val_q & i_rdy;

   // Next-state logic.
   // The FSM decides which word and carry the next beat uses. Then the beat
   // itself is computed from those next values, so the output flops load the
   // finished word together with the state change.
   // cnext_q holds the carry-out of the beat currently on the outputs.
   // A handshake simply moves cnext_q into carry_q.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      carry_d   = carry_q;
      cnext_d   = cnext_q;
      op_d      = op_q;
      o_rdy_d   = o_rdy_q;
      o_val_d   = o_val_q;
      o_dat_d   = o_dat_q;
      o_sop_d   = o_sop_q;
      o_eop_d   = o_eop_q;
      o_ovf_d   = o_ovf_q;
      load_beat = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (i_val) begin
               op_d      = i_red;
               state_d   = ST_SEND;
               idx_d     = '0;
               carry_d   = '0;
               o_rdy_d   = 1'b0;
               o_val_d   = 1'b1;
               load_beat = 1'b1;
            end
         end
         ST_SEND: begin
            if (hs) begin
               carry_d = cnext_q;
               if (idx_q == LAST_IDX) begin
                  state_d = ST_IDLE;
                  idx_d   = '0;
                  o_rdy_d = 1'b1;
                  o_val_d = 1'b0;
                  o_sop_d = 1'b0;
                  o_eop_d = 1'b0;
                  o_ovf_d = 1'b0;
               end else begin
                  idx_d     = idx_q + IDX_ONE;
                  load_beat = 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            idx_d   = '0;
            o_rdy_d = 1'b1;
            o_val_d = 1'b0;
         end
      endcase

      nxt_word = op_d[int'(idx_d) * RED_BITS +: RED_BITS];
      nxt_sum  = {1'b0, nxt_word} + {{WRD_BITS{1'b0}}, carry_d};

      if (load_beat) begin
         o_dat_d = nxt_sum[WRD_BITS-1:0];
         cnext_d = nxt_sum[SUM_BITS-1:WRD_BITS];
         o_sop_d = (idx_d == '0);
         o_eop_d = (idx_d == LAST_IDX);
         o_ovf_d = (idx_d == LAST_IDX) && (cnext_d != '0);
      end
   end

   // Control, carry and output registers.
   // Reset drops back to IDLE at once and abandons any frame in flight.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         carry_q <= '0;
         cnext_q <= '0;
         o_rdy_q <= 1'b1;
         o_val_q <= 1'b0;
         o_dat_q <= '0;
         o_sop_q <= 1'b0;
         o_eop_q <= 1'b0;
         o_ovf_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         cnext_q <= cnext_d;
         o_rdy_q <= o_rdy_d;
         o_val_q <= o_val_d;
         o_dat_q <= o_dat_d;
         o_sop_q <= o_sop_d;
         o_eop_q <= o_eop_d;
         o_ovf_q <= o_ovf_d;
      end
   end

   // The operand store is a wide datapath register with no reset.
   // It is only read after an accept has loaded it.
   always_ff @(posedge i_clk) begin
      op_q <= op_d;
   end

   assign o_rdy = o_rdy_q;
   assign o_val = o_val_q;
   assign o_dat = o_dat_q;
   assign o_sop = o_sop_q;
   assign o_eop = o_eop_q;
   assign o_ovf = o_ovf_q;

endmodule
